// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the multi-channel servo PWM generator.
// Default timing constants, the position word type and the clamp helper.
package servo_pwm_pkg;

    localparam int unsigned DEF_NUM_CH    = 2;
    localparam int unsigned DEF_POS_W     = 11;
    localparam int unsigned DEF_MAX_POS   = 1000;
    localparam int unsigned DEF_MIN_PULSE = 1000;
    localparam int unsigned DEF_PERIOD    = 3000;
    localparam int unsigned DEF_CNT_W     = 12;
    localparam int unsigned DEF_TICK_DIV  = 100;
    localparam int unsigned DEF_SLEW_STEP = 16;

    typedef logic [DEF_POS_W-1:0] pos_t;

    // Saturate a requested position at the mechanical limit.
    function automatic logic [31:0] clamp_pos(input logic [31:0] value,
                                              input logic [31:0] max_pos);
        return (value > max_pos) ? max_pos : value;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: shadow/active position registers and the pulse comparator.
// Optional macro SERVO_SLEW_EN limits how far active may move per commit.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int unsigned POS_W     = DEF_POS_W,
    parameter int unsigned MAX_POS   = DEF_MAX_POS,
    parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
`ifdef SERVO_SLEW_EN
    parameter int unsigned SLEW_STEP = DEF_SLEW_STEP,
`endif
    parameter int unsigned CNT_W     = DEF_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [POS_W-1:0] wr_data,
    input  logic             commit,
    input  logic [CNT_W-1:0] cntr,
    output logic             pwm
);

    localparam logic [POS_W-1:0] RESET_POS = POS_W'(MAX_POS / 2);

    logic [POS_W-1:0] shadow;
    logic [POS_W-1:0] active;
    logic [POS_W-1:0] next_active;
    logic [CNT_W-1:0] threshold;

`ifdef SERVO_SLEW_EN
    localparam logic [POS_W-1:0] STEP = POS_W'(SLEW_STEP);
    logic [POS_W-1:0] diff;

    // Move active toward shadow by at most STEP per commit.
    always_comb begin
        next_active = active;
        diff        = '0;
        if (shadow > active) begin
            diff        = shadow - active;
            next_active = active + ((diff > STEP) ? STEP : diff);
        end else if (shadow < active) begin
            diff        = active - shadow;
            next_active = active - ((diff > STEP) ? STEP : diff);
        end
    end
`else
    assign next_active = shadow;
`endif

    assign threshold = CNT_W'(MIN_PULSE) + CNT_W'(active);

    // Shadow takes writes anytime; active only changes at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= RESET_POS;
            active <= RESET_POS;
        end else begin
            if (wr_en)
                shadow <= POS_W'(clamp_pos(32'(wr_data), MAX_POS));
            if (commit)
                active <= next_active;
        end
    end

    // Registered comparator output, one clock behind the period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm <= 1'b0;
        else
            pwm <= (cntr < threshold);
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: prescaler, period counter, commit
// timing, valid/ready write port and per-channel decode.
// Optional macro SERVO_SLEW_EN enables per-period slew limiting in each channel.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned POS_W     = DEF_POS_W,
    parameter int unsigned MAX_POS   = DEF_MAX_POS,
    parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned SLEW_STEP = DEF_SLEW_STEP,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pos_valid,
    input  logic [CH_W-1:0]   pos_ch,
    input  logic [POS_W-1:0]  pos_data,
    output logic              pos_ready,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Elaboration-time sanity checks on the parameter set.
    if (PERIOD <= MIN_PULSE + MAX_POS) begin : g_bad_period
        $error("PERIOD must exceed MIN_PULSE + MAX_POS");
    end
    if (PERIOD - 1 >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for PERIOD-1");
    end
    if (SLEW_STEP == 0) begin : g_bad_step
        $error("SLEW_STEP must be non-zero");
    end

    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   cntr;
    logic               tick;
    logic               wrap;
    logic               ready_en;
    logic               accept;

    assign tick      = (presc == PRESC_W'(TICK_DIV - 1));
    assign wrap      = tick && (cntr == CNT_W'(PERIOD - 1));
    // Writes are refused only in the commit cycle so shadow is stable while copied.
    assign pos_ready = ready_en && !wrap;
    assign accept    = pos_valid && pos_ready;

    // Prescaler: one tick every TICK_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    // Period counter: advances on tick, wraps after PERIOD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cntr <= '0;
        else if (wrap)
            cntr <= '0;
        else if (tick)
            cntr <= cntr + 1'b1;
    end

    // period_start marks the first cycle of cntr==0; ready opens one edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
            ready_en     <= 1'b0;
        end else begin
            period_start <= wrap;
            ready_en     <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .POS_W     (POS_W),
            .MAX_POS   (MAX_POS),
            .MIN_PULSE (MIN_PULSE),
`ifdef SERVO_SLEW_EN
            .SLEW_STEP (SLEW_STEP),
`endif
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (accept && (int'(pos_ch) == i)),
            .wr_data (pos_data),
            .commit  (wrap),
            .cntr    (cntr),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi (TICK_DIV=2, other parameters default).
// A second instance with NUM_CH=3 exercises an out-of-range channel index.
// Pulse widths are measured in clocks per period window and checked against
// a scoreboard queue filled when stimulus is applied.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        pos_valid = 1'b0;
    logic [0:0]  pos_ch    = '0;
    logic [10:0] pos_data  = '0;
    logic        pos_ready;
    logic [1:0]  pwm_out;
    logic        period_start;

    logic        v3  = 1'b0;
    logic [1:0]  ch3 = '0;
    logic [10:0] d3  = '0;
    logic        rdy3;
    logic [2:0]  pwm3;
    logic        ps3;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {int w0; int w1; int x;} exp_t;
    typedef struct {int w0; int w1; int x0; int x1; int x2;} meas_t;

    exp_t  exp_q[$];
    meas_t last;
    int    win_cnt = 0;
    int    acc[5];
    bit    ps_skew = 1'b0;

    servo_pwm_multi #(.TICK_DIV(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pos_valid    (pos_valid),
        .pos_ch       (pos_ch),
        .pos_data     (pos_data),
        .pos_ready    (pos_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    servo_pwm_multi #(.NUM_CH(3), .TICK_DIV(2)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .pos_valid    (v3),
        .pos_ch       (ch3),
        .pos_data     (d3),
        .pos_ready    (rdy3),
        .pwm_out      (pwm3),
        .period_start (ps3)
    );

    always #5 clk = ~clk;

    // Window monitor: high-clock counts per channel between period_start pulses.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) acc[i] = 0;
        end else begin
            if (ps3 !== period_start) ps_skew = 1'b1;
            if (period_start === 1'b1) begin
                last = '{acc[0], acc[1], acc[2], acc[3], acc[4]};
                win_cnt++;
                for (int i = 0; i < 5; i++) acc[i] = 0;
            end
            acc[0] += int'(pwm_out[0]);
            acc[1] += int'(pwm_out[1]);
            acc[2] += int'(pwm3[0]);
            acc[3] += int'(pwm3[1]);
            acc[4] += int'(pwm3[2]);
        end
    end

    // Wait for the next window to close; -1 widths on timeout.
    task automatic wait_win(output meas_t m);
        int base = win_cnt;
        bit got  = 1'b0;
        for (int i = 0; i < 7000 && !got; i++) begin
            @(posedge clk);
            if (win_cnt != base) got = 1'b1;
        end
        if (got) m = last;
        else     m = '{-1, -1, -1, -1, -1};
    endtask

    // Single valid/ready write, bounded to 8 cycles.
    task automatic do_write(input bit to3, input int ch, input int data, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (to3) begin
            v3 = 1'b1; ch3 = 2'(ch); d3 = 11'(data);
        end else begin
            pos_valid = 1'b1; pos_ch = 1'(ch); pos_data = 11'(data);
        end
        for (int i = 0; i < 8 && !ok; i++) begin
            if ((to3 ? rdy3 : pos_ready) === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        v3 = 1'b0;
        pos_valid = 1'b0;
    endtask

    task automatic test_reset();
        meas_t m;
        exp_t  e;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b00 || pwm3 !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pwm: got %b/%b, want 00/000", pwm_out, pwm3);
        end
        vectors++;
        if (period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_period_start: got %b, want 0", period_start);
        end
        vectors++;
        if (pos_ready !== 1'b0 || rdy3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b/%b, want 0/0", pos_ready, rdy3);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (pos_ready !== 1'b1 || rdy3 !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b/%b, want 1/1", pos_ready, rdy3);
        end
        repeat (2) exp_q.push_back('{3000, 3000, 3000});
        repeat (2) begin
            wait_win(m);
            e = exp_q.pop_front();
            vectors++;
            if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
                miscompares++;
                $display("FAIL reset_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                         m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
            end
        end
    endtask

    task automatic test_write_mid();
        meas_t m;
        exp_t  e;
        bit    ok0, ok1;
        repeat (2000) @(negedge clk);
        do_write(1'b0, 0, 0, ok0);
        do_write(1'b0, 1, 1000, ok1);
        exp_q.push_back('{3000, 3000, 3000});
        exp_q.push_back('{2000, 4000, 3000});
        vectors++;
        if (ok0 !== 1'b1 || ok1 !== 1'b1) begin
            miscompares++;
            $display("FAIL write_mid_handshake: got %b%b, want 11", ok0, ok1);
        end
        repeat (2) begin
            wait_win(m);
            e = exp_q.pop_front();
            vectors++;
            if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
                miscompares++;
                $display("FAIL write_mid_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                         m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
            end
        end
    endtask

    task automatic test_clamp();
        meas_t m;
        exp_t  e;
        bit    ok0, ok1;
        repeat (2000) @(negedge clk);
        do_write(1'b0, 1, 2047, ok0);
        do_write(1'b0, 0, 1001, ok1);
        exp_q.push_back('{2000, 4000, 3000});
        exp_q.push_back('{4000, 4000, 3000});
        vectors++;
        if (ok0 !== 1'b1 || ok1 !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_handshake: got %b%b, want 11", ok0, ok1);
        end
        repeat (2) begin
            wait_win(m);
            e = exp_q.pop_front();
            vectors++;
            if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
                miscompares++;
                $display("FAIL clamp_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                         m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
            end
        end
    endtask

    task automatic test_bad_channel(input int w0, input int w1);
        meas_t m;
        exp_t  e;
        bit    ok;
        repeat (2000) @(negedge clk);
        do_write(1'b1, 3, 0, ok);
        exp_q.push_back('{w0, w1, 3000});
        exp_q.push_back('{w0, w1, 3000});
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_ch_handshake: got %b, want 1", ok);
        end
        repeat (2) begin
            wait_win(m);
            e = exp_q.pop_front();
            vectors++;
            if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
                miscompares++;
                $display("FAIL bad_ch_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                         m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
            end
        end
        vectors++;
        if (ps_skew !== 1'b0) begin
            miscompares++;
            $display("FAIL period_start_align: got skew=%b, want 0", ps_skew);
        end
    endtask

    task automatic test_back_to_back();
        meas_t m;
        exp_t  e;
        // Entry is just after the first negedge of a window; offset 5999 is the wrap cycle.
        repeat (5998) @(negedge clk);
        vectors++;
        if (pos_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready_before_wrap: got %b, want 1", pos_ready);
        end
        @(negedge clk);
        pos_valid = 1'b1; pos_ch = 1'b0; pos_data = 11'd250;
        vectors++;
        if (pos_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_in_wrap: got %b, want 0", pos_ready);
        end
        @(negedge clk);
        vectors++;
        if (pos_ready !== 1'b1 || period_start !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready_after_wrap: got ready=%b ps=%b, want 1 1", pos_ready, period_start);
        end
        exp_q.push_back('{4000, 4000, 3000});
        exp_q.push_back('{2500, 4000, 3000});
        @(negedge clk);
        pos_valid = 1'b0;
        repeat (2) begin
            wait_win(m);
            e = exp_q.pop_front();
            vectors++;
            if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
                miscompares++;
                $display("FAIL b2b_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                         m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
            end
        end
    endtask

    task automatic test_async_reset();
        meas_t m;
        exp_t  e;
        int    k;
        bit    found;
        repeat (1400) @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b11) begin
            miscompares++;
            $display("FAIL pwm_before_rst: got %b, want 11", pwm_out);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (pwm_out !== 2'b00 || pwm3 !== 3'b000) begin
            miscompares++;
            $display("FAIL pwm_async_drop: got %b/%b, want 00/000", pwm_out, pwm3);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 7000 && !found; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                found = 1'b1;
                k = i;
            end
        end
        vectors++;
        if (k !== 6000) begin
            miscompares++;
            $display("FAIL period_after_rst: got %0d clks, want 6000", k);
        end
        @(posedge clk);
        exp_q.push_back('{3000, 3000, 3000});
        wait_win(m);
        e = exp_q.pop_front();
        vectors++;
        if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
            miscompares++;
            $display("FAIL async_rst_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                     m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
        end
    endtask

`ifdef SERVO_SLEW_EN
    task automatic test_slew();
        meas_t m;
        exp_t  e;
        bit    ok;
        repeat (2000) @(negedge clk);
        do_write(1'b0, 0, 1000, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL slew_handshake: got %b, want 1", ok);
        end
        exp_q.push_back('{3000, 3000, 3000});
        for (int p = 1; p <= 5; p++)
            exp_q.push_back('{2 * (1500 + 16 * p), 3000, 3000});
        repeat (6) begin
            wait_win(m);
            e = exp_q.pop_front();
            vectors++;
            if (m.w0 !== e.w0 || m.w1 !== e.w1 || m.x0 !== e.x || m.x1 !== e.x || m.x2 !== e.x) begin
                miscompares++;
                $display("FAIL slew_window: got %0d %0d %0d/%0d/%0d, want %0d %0d %0d",
                         m.w0, m.w1, m.x0, m.x1, m.x2, e.w0, e.w1, e.x);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SERVO_SLEW_EN
        test_bad_channel(3000, 3000);
        test_async_reset();
        test_slew();
`else
        test_write_mid();
        test_clamp();
        test_bad_channel(4000, 4000);
        test_back_to_back();
        test_async_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
